// File: rtl/fm_3d_mu_burst_rd_resp_pkg.sv
// Shared widths and FSM encoding for the 3D memory-unit burst-read responder.
// Width defaults track the interconnect address/length/data widths.
package fm_3d_mu_burst_rd_resp_pkg;

  localparam int unsigned AW_DEF = 22;
  localparam int unsigned LW_DEF = 6;
  localparam int unsigned DW_DEF = 128;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/fm_3d_mu_cmd_fifo.sv
// Synchronous command FIFO holding {adrs, len} entries for the burst responder.
// Head entry is presented combinationally; push is accepted when full if a pop happens too.
module fm_3d_mu_cmd_fifo #(
  parameter int unsigned P_W     = 28,
  parameter int unsigned P_DEPTH = 2
) (
  input  logic           clk_core,
  input  logic           rst_x,
  input  logic           push_i,
  input  logic [P_W-1:0] data_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output logic [P_W-1:0] data_o
);

  localparam int unsigned AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  logic [P_W-1:0] mem_q [P_DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           do_wr;
  logic           do_rd;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_rd   = pop_i & ~empty_o;
  assign do_wr   = push_i & (~full_o | do_rd);

  always_ff @(posedge clk_core) begin
    if (rst_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_core) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fm_3d_mu_burst_rd_resp.sv
// Burst-read responder: queues {adrs, len} commands, splits them into single-beat
// memory reads with bounded outstanding count, and returns data as strobed beats.
module fm_3d_mu_burst_rd_resp
  import fm_3d_mu_burst_rd_resp_pkg::*;
#(
  parameter int unsigned P_AW       = AW_DEF,
  parameter int unsigned P_LW       = LW_DEF,
  parameter int unsigned P_DW       = DW_DEF,
  parameter int unsigned P_CQ_DEPTH = 2,
  parameter int unsigned P_MAX_OUT  = 8
) (
  input  logic            clk_core,
  input  logic            rst_x,
  input  logic            i_req_co,
  input  logic [P_AW-1:0] i_adrs_co,
  output logic            o_ack_co,
  input  logic [P_LW-1:0] i_len_co,
  output logic            o_strr_co,
  output logic [P_DW-1:0] o_dbr_co,
  output logic            o_mem_req,
  output logic [P_AW-1:0] o_mem_adrs,
  input  logic            i_mem_ack,
  input  logic            i_mem_rvalid,
  input  logic [P_DW-1:0] i_mem_dt,
  output logic            o_busy
);

  localparam int unsigned CW = P_AW + P_LW;
  localparam int unsigned OW = $clog2(P_MAX_OUT + 1);

  state_e          state_q, state_d;
  logic [P_AW-1:0] cur_adrs_q, cur_adrs_d;
  logic [P_LW-1:0] rem_q, rem_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            strr_q, strr_d;
  logic [P_DW-1:0] dbr_q, dbr_d;

  logic            cq_full;
  logic            cq_empty;
  logic            cq_pop;
  logic [CW-1:0]   cq_data;
  logic [P_AW-1:0] head_adrs;
  logic [P_LW-1:0] head_len;
  logic            mem_hs;
  logic            rd_ret;

  fm_3d_mu_cmd_fifo #(
    .P_W     (CW),
    .P_DEPTH (P_CQ_DEPTH)
  ) u_cmd_fifo (
    .clk_core (clk_core),
    .rst_x    (rst_x),
    .push_i   (o_ack_co),
    .data_i   ({i_adrs_co, i_len_co}),
    .pop_i    (cq_pop),
    .full_o   (cq_full),
    .empty_o  (cq_empty),
    .data_o   (cq_data)
  );

  assign o_ack_co  = i_req_co & ~cq_full;
  assign head_adrs = cq_data[CW-1:P_LW];
  assign head_len  = cq_data[P_LW-1:0];
  assign mem_hs    = mem_req_q & i_mem_ack;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign rd_ret    = i_mem_rvalid & (out_cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    cur_adrs_d = cur_adrs_q;
    rem_d      = rem_q;
    cq_pop     = 1'b0;
    out_cnt_d  = out_cnt_q;
    strr_d     = rd_ret;
    dbr_d      = dbr_q;

    case (state_q)
      S_IDLE: begin
        if (!cq_empty) begin
          cq_pop     = 1'b1;
          cur_adrs_d = head_adrs;
          rem_d      = head_len;
          if (head_len != '0) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_hs) begin
          cur_adrs_d = cur_adrs_q + P_AW'(1);
          rem_d      = rem_q - P_LW'(1);
          if (rem_q == P_LW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case ({mem_hs, rd_ret})
      2'b10:   out_cnt_d = out_cnt_q + OW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Request is registered from next-state values so it holds until acked.
    mem_req_d = (state_d == S_ISSUE) && (out_cnt_d < OW'(P_MAX_OUT));
    if (rd_ret) dbr_d = i_mem_dt;
  end

  always_ff @(posedge clk_core) begin
    if (rst_x) begin
      state_q    <= S_IDLE;
      cur_adrs_q <= '0;
      rem_q      <= '0;
      out_cnt_q  <= '0;
      mem_req_q  <= 1'b0;
      strr_q     <= 1'b0;
      dbr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_adrs_q <= cur_adrs_d;
      rem_q      <= rem_d;
      out_cnt_q  <= out_cnt_d;
      mem_req_q  <= mem_req_d;
      strr_q     <= strr_d;
      dbr_q      <= dbr_d;
    end
  end

  assign o_mem_req  = mem_req_q;
  assign o_mem_adrs = cur_adrs_q;
  assign o_strr_co  = strr_q;
  assign o_dbr_co   = dbr_q;
  assign o_busy     = ~cq_empty | (state_q == S_ISSUE) | (out_cnt_q != '0) | strr_q;

endmodule

// File: tb/tb_fm_3d_mu_burst_rd_resp.sv
// Scoreboard bench for the burst-read responder: expected addresses/beats are queued
// at command acceptance and popped by a negedge monitor against a behavioural memory.
module tb_fm_3d_mu_burst_rd_resp;

  localparam int unsigned AW = 22;
  localparam int unsigned LW = 6;
  localparam int unsigned DW = 128;

  logic          clk_core = 1'b0;
  logic          rst_x = 1'b1;
  logic          i_req_co = 1'b0;
  logic [AW-1:0] i_adrs_co = '0;
  logic          o_ack_co;
  logic [LW-1:0] i_len_co = '0;
  logic          o_strr_co;
  logic [DW-1:0] o_dbr_co;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_adrs;
  logic          i_mem_ack = 1'b0;
  logic          i_mem_rvalid = 1'b0;
  logic [DW-1:0] i_mem_dt = '0;
  logic          o_busy;

  fm_3d_mu_burst_rd_resp #(
    .P_AW(AW), .P_LW(LW), .P_DW(DW), .P_CQ_DEPTH(2), .P_MAX_OUT(8)
  ) dut (
    .clk_core(clk_core), .rst_x(rst_x), .i_req_co(i_req_co), .i_adrs_co(i_adrs_co),
    .o_ack_co(o_ack_co), .i_len_co(i_len_co), .o_strr_co(o_strr_co), .o_dbr_co(o_dbr_co),
    .o_mem_req(o_mem_req), .o_mem_adrs(o_mem_adrs), .i_mem_ack(i_mem_ack),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_dt(i_mem_dt), .o_busy(o_busy)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } mem_ent_t;

  int passes = 0;
  int total = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int strr_cnt = 0;
  int model_out = 0;
  int ack_mode = 0;     // 0: always ack, 1: random ack, 2: ack withheld
  bit hold_rv = 0;
  bit rv_rand = 0;
  int lat_min = 3;
  int lat_max = 3;

  logic [AW-1:0] exp_adrs[$];
  logic [DW-1:0] exp_data[$];
  mem_ent_t      pipe[$];
  int            hs_cyc_q[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {32'(a) * 32'h9E37_79B1, ~32'(a), 32'(a) + 32'h0001_2345, {10'h2A5, a}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Memory model: ack policy and in-order read returns with configurable latency.
  initial begin
    forever begin
      tick();
      cyc++;
      case (ack_mode)
        0:       i_mem_ack = 1'b1;
        1:       i_mem_ack = ($urandom_range(0, 3) != 0);
        default: i_mem_ack = 1'b0;
      endcase
      if (!hold_rv && pipe.size() > 0 && pipe[0].due <= cyc &&
          !(rv_rand && $urandom_range(0, 3) == 0)) begin
        i_mem_rvalid = 1'b1;
        i_mem_dt     = pipe[0].data;
        void'(pipe.pop_front());
      end else begin
        i_mem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: handshakes, beats and request stability, sampled at negedge.
  initial begin
    bit            prev_valid = 0;
    bit            prev_req = 0;
    bit            prev_ack = 0;
    logic [AW-1:0] prev_adrs = '0;
    forever begin
      @(negedge clk_core);
      if (rst_x) begin
        model_out  = 0;
        prev_valid = 0;
      end else begin
        if (prev_valid && prev_req && !prev_ack) begin
          chk("req_hold", 128'(o_mem_req), 128'(1));
          chk("adrs_hold", 128'(o_mem_adrs), 128'(prev_adrs));
        end
        if (o_mem_req && i_mem_ack) begin
          hs_cnt++;
          hs_cyc_q.push_back(cyc);
          chk("out_limit", 128'(model_out < 8), 128'(1));
          if (exp_adrs.size() == 0) begin
            total++;
            $display("FAIL mem_adrs: unexpected request 0x%0h, required none", o_mem_adrs);
          end else begin
            chk("mem_adrs", 128'(o_mem_adrs), 128'(exp_adrs.pop_front()));
          end
          pipe.push_back('{mem_word(o_mem_adrs), cyc + int'($urandom_range(lat_min, lat_max))});
          model_out++;
        end
        if (i_mem_rvalid && model_out > 0) model_out--;
        if (o_strr_co) begin
          strr_cnt++;
          if (exp_data.size() == 0) begin
            total++;
            $display("FAIL beat: unexpected strr data 0x%0h, required none", o_dbr_co);
          end else begin
            chk("beat_data", o_dbr_co, exp_data.pop_front());
          end
        end
        prev_valid = 1;
        prev_req   = o_mem_req;
        prev_ack   = i_mem_ack;
        prev_adrs  = o_mem_adrs;
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l, output int waited);
    waited    = 0;
    i_req_co  = 1'b1;
    i_adrs_co = a;
    i_len_co  = l;
    forever begin
      @(negedge clk_core);
      if (o_ack_co) break;
      waited++;
      if (waited > 500) begin
        total++;
        $display("FAIL ack_timeout: no ack after %0d cycles, required ack", waited);
        break;
      end
      tick();
    end
    if (waited <= 500) begin
      for (int i = 0; i < int'(l); i++) begin
        exp_adrs.push_back(AW'(a + AW'(i)));
        exp_data.push_back(mem_word(AW'(a + AW'(i))));
      end
    end
    tick();
    i_req_co = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_adrs.size() != 0 || exp_data.size() != 0 || pipe.size() != 0 || o_busy)
           && n < 3000) begin
      tick();
      n++;
    end
    chk(name, 128'(n < 3000), 128'(1));
  endtask

  task automatic do_reset();
    rst_x    = 1'b1;
    i_req_co = 1'b0;
    tick();
    rst_x = 1'b0;
    exp_adrs.delete();
    exp_data.delete();
    @(negedge clk_core);
    chk("rst_ack", 128'(o_ack_co), 128'(0));
    chk("rst_strr", 128'(o_strr_co), 128'(0));
    chk("rst_dbr", o_dbr_co, 128'(0));
    chk("rst_mem_req", 128'(o_mem_req), 128'(0));
    chk("rst_mem_adrs", 128'(o_mem_adrs), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    tick();
  endtask

  initial begin
    int w1, w2, w3, w4, h0, s0, n;
    do_reset();

    // Single burst, fixed latency 3, ack every cycle.
    h0 = hs_cnt; s0 = strr_cnt; hs_cyc_q.delete();
    send(22'h000100, 6'd4, w1);
    n = 0;
    while (strr_cnt - s0 < 4 && n < 100) begin tick(); n++; end
    chk("single_beats", 128'(strr_cnt - s0), 128'(4));
    @(negedge clk_core);
    chk("single_busy_fall", 128'(o_busy), 128'(0));
    chk("single_hs", 128'(hs_cnt - h0), 128'(4));
    if (hs_cyc_q.size() == 4) chk("single_consec", 128'(hs_cyc_q[3] - hs_cyc_q[0]), 128'(3));
    else chk("single_hs_q", 128'(hs_cyc_q.size()), 128'(4));
    tick();
    drain("single_drain");

    // Back-to-back requests; the fourth finds the queue full.
    send(22'h10, 6'd2, w1);
    send(22'h20, 6'd2, w2);
    send(22'h30, 6'd2, w3);
    send(22'h40, 6'd2, w4);
    chk("b2b_ack1", 128'(w1), 128'(0));
    chk("b2b_ack2", 128'(w2), 128'(0));
    chk("b2b_hold4", 128'(w4 != 0), 128'(1));
    drain("b2b_drain");

    // Throttle on outstanding reads.
    hold_rv = 1; h0 = hs_cnt; s0 = strr_cnt;
    send(22'h001000, 6'd12, w1);
    repeat (20) tick();
    chk("thr_hs", 128'(hs_cnt - h0), 128'(8));
    chk("thr_req_low", 128'(o_mem_req), 128'(0));
    chk("thr_adrs", 128'(o_mem_adrs), 128'(22'h001008));
    hold_rv = 0;
    drain("thr_drain");
    chk("thr_beats", 128'(strr_cnt - s0), 128'(12));

    // Zero-length command.
    h0 = hs_cnt; s0 = strr_cnt;
    send(22'h000500, 6'd0, w1);
    @(negedge clk_core);
    chk("len0_busy1", 128'(o_busy), 128'(1));
    tick();
    @(negedge clk_core);
    chk("len0_busy0", 128'(o_busy), 128'(0));
    repeat (4) tick();
    chk("len0_no_req", 128'(hs_cnt - h0), 128'(0));
    chk("len0_no_strr", 128'(strr_cnt - s0), 128'(0));

    // Address wrap.
    s0 = strr_cnt;
    send(22'h3FFFFE, 6'd4, w1);
    drain("wrap_drain");
    chk("wrap_beats", 128'(strr_cnt - s0), 128'(4));

    // Memory stall mid-burst.
    h0 = hs_cnt;
    send(22'h002000, 6'd10, w1);
    n = 0;
    while (hs_cnt - h0 < 4 && n < 100) begin tick(); n++; end
    ack_mode = 2;
    repeat (5) tick();
    chk("stall_req", 128'(o_mem_req), 128'(1));
    ack_mode = 0;
    drain("stall_drain");
    chk("stall_hs", 128'(hs_cnt - h0), 128'(10));

    // Reset after three of eight reads issued; stale returns must be dropped.
    hold_rv = 1; h0 = hs_cnt;
    send(22'h000200, 6'd8, w1);
    n = 0;
    while (hs_cnt - h0 < 3 && n < 100) begin tick(); n++; end
    do_reset();
    chk("rst_inflight", 128'(pipe.size()), 128'(3));
    s0 = strr_cnt;
    hold_rv = 0;
    repeat (10) tick();
    chk("rst_stale_drop", 128'(strr_cnt - s0), 128'(0));
    send(22'h000321, 6'd1, w1);
    drain("rst_new_drain");
    chk("rst_new_beat", 128'(strr_cnt - s0), 128'(1));

    // Randomized traffic.
    ack_mode = 1; rv_rand = 1; lat_min = 1; lat_max = 6;
    s0 = strr_cnt;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      a = ($urandom_range(0, 3) == 0) ? AW'(22'h3FFFF0 + 22'($urandom_range(0, 15))) : AW'($urandom);
      l = LW'($urandom_range(0, 20));
      n += int'(l);
      send(a, l, w1);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("rand_drain");
    chk("rand_beats", 128'(strr_cnt - s0), 128'(n));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
